int_controller: RTL

Interrupt source controller that produces the single `interrupt` request consumed by the jump-control stage of the MIPS pipeline. Latches rising edges on several external request lines, arbitrates by fixed priority, issues exactly one one-cycle `interrupt` pulse per event, then blocks further requests until the handler's RET is decoded. This enforces the single-level return-address save in jump control.

---
 rtl/int_controller.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/int_controller.sv
// int_controller
// Interrupt source controller for the jump-control stage. Rising edges on the
// request lines are latched as pending events. The lowest eligible index wins
// and is issued as a single one-cycle interrupt pulse. After that, no further
// issue happens until the handler's RET is decoded, because jump control saves
// only one return address.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | no handler active; issue when a line is eligible and the
//           | opcode at decode is not jump-class
//   ISSUE   | interrupt pulse cycle, always followed by SERVICE
//   SERVICE | handler running; wait for RET, pending keeps accumulating
module int_controller #(
    parameter int NUM_IRQ = 4,
    parameter int ID_W    = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic [NUM_IRQ-1:0] irq_mask,
    input  logic               int_enable,
    input  logic [5:0]         op,
    input  logic [NUM_IRQ-1:0] pend_clr,
    output logic               interrupt,
    output logic [ID_W-1:0]    cause_id,
    output logic               in_service,
    output logic [NUM_IRQ-1:0] pending,
    output logic [7:0]         irq_count
);

    localparam logic [5:0] OP_RET = 6'b010000;
    localparam logic [5:0] OP_JMP = 6'b011000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [NUM_IRQ-1:0]   irq_d;
    logic [NUM_IRQ-1:0]   rise;
    logic [NUM_IRQ-1:0]   eligible;
    logic                 any_eligible;
    logic [ID_W-1:0]      winner;
    logic                 jump_op;
    logic                 grant;
    logic                 interrupt_d;
    logic                 in_service_d;
    logic [NUM_IRQ-1:0]   issue_vec;
    logic [NUM_IRQ-1:0]   pending_d;

    // Edge detect and eligibility; int_enable gates every line at once.
    always_comb begin
        rise         = irq & ~irq_d;
        eligible     = int_enable ? (pending & ~irq_mask) : '0;
        any_eligible = |eligible;
    end

    // Jump-class opcodes: the return address would be corrupted if an issue
    // landed on them. 0111xx covers JV/JNV/JZ/JNZ.
    always_comb begin
        jump_op = (op == OP_JMP) || (op == OP_RET) || (op[5:2] == 4'b0111);
    end

    // Fixed priority: lowest eligible index wins (scan downwards so the last
    // assignment is the lowest set bit).
    always_comb begin
        winner = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winner = ID_W'(i);
            end
        end
    end

    // Next-state logic and next values of the registered outputs.
    always_comb begin
        state_d      = state_q;
        grant        = 1'b0;
        interrupt_d  = 1'b0;
        in_service_d = in_service;
        case (state_q)
            IDLE: begin
                if (any_eligible && !jump_op) begin
                    state_d      = ISSUE;
                    grant        = 1'b1;
                    interrupt_d  = 1'b1;
                    in_service_d = 1'b1;
                end
            end
            ISSUE: begin
                state_d = SERVICE;
            end
            SERVICE: begin
                if (op == OP_RET) begin
                    state_d      = IDLE;
                    in_service_d = 1'b0;
                end
            end
            default: begin
                state_d      = IDLE;
                in_service_d = 1'b0;
            end
        endcase
    end

    // Pending update: a fresh edge always survives (even on the issued bit,
    // where it counts as a second event); otherwise issue or pend_clr clears.
    always_comb begin
        issue_vec = grant ? (NUM_IRQ'(1) << winner) : '0;
        pending_d = rise | (pending & ~issue_vec & ~pend_clr);
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Registered outputs, edge-detect history and the issue counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_d      <= '0;
            pending    <= '0;
            interrupt  <= 1'b0;
            in_service <= 1'b0;
            cause_id   <= '0;
            irq_count  <= 8'd0;
        end else begin
            irq_d      <= irq;
            pending    <= pending_d;
            interrupt  <= interrupt_d;
            in_service <= in_service_d;
            if (grant) begin
                cause_id  <= winner;
                irq_count <= irq_count + 8'd1;
            end
        end
    end

endmodule
